// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        MULTI = 1'b1
    } hazState_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int CNT_W = 16;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forwarding comparator: picks the newest in-flight producer of rsE.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rsE,
    input  logic [4:0] rdM,
    input  logic       RegWriteM,
    input  logic [4:0] rdW,
    input  logic       RegWriteW,
    output logic [1:0] fwd
);

    // M is younger than W, so it takes priority when both match.
    always_comb begin
        fwd = FWD_RF;
        if (RegWriteM && (rdM != 5'd0) && (rdM == rsE)) begin
            fwd = FWD_M;
        end else if (RegWriteW && (rdW != 5'd0) && (rdW == rsE)) begin
            fwd = FWD_W;
        end else begin
            fwd = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: forwarding selects, load-use bubbles,
// branch squashes and multi-cycle execute occupancy.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 32,
    parameter logic [31:0] STALL_SAT     = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1D,
    input  logic [4:0]  rs2D,
    input  logic [4:0]  rs1E,
    input  logic [4:0]  rs2E,
    input  logic [4:0]  rdE,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic [4:0]  rdM,
    input  logic        RegWriteM,
    input  logic [4:0]  rdW,
    input  logic        RegWriteW,
    input  logic        PCsrcE,
    input  logic        MultiE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        busy,
    output logic [31:0] stall_cycles
);

    localparam bit              MULTI_EN  = (MULDIV_CYCLES > 32'd1);
    // Entry cycle already counts as the first stall cycle.
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(32'(MULDIV_CYCLES) - 32'd2);

    hazState_t        stateR;
    hazState_t        stateNext;
    logic [CNT_W-1:0] cntR;
    logic [CNT_W-1:0] cntNext;
    logic [1:0]       fwdA;
    logic [1:0]       fwdB;
    logic             loadUse;

    fwd_sel uFwdA (
        .rsE       (rs1E),
        .rdM       (rdM),
        .RegWriteM (RegWriteM),
        .rdW       (rdW),
        .RegWriteW (RegWriteW),
        .fwd       (fwdA)
    );

    fwd_sel uFwdB (
        .rsE       (rs2E),
        .rdM       (rdM),
        .RegWriteM (RegWriteM),
        .rdW       (rdW),
        .RegWriteW (RegWriteW),
        .fwd       (fwdB)
    );

    assign loadUse = MemtoRegE & RegWriteE & (rdE != 5'd0) &
                     ((rdE == rs1D) | (rdE == rs2D));

    // Next-state and stall/flush decode; everything is forced quiet while in reset.
    always_comb begin
        stateNext = stateR;
        cntNext   = cntR;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        busy      = 1'b0;
        if (rst) begin
            stateNext = RUN;
            cntNext   = '0;
        end else begin
            ForwardAE = fwdA;
            ForwardBE = fwdB;
            busy      = (stateR == MULTI);
            case (stateR)
                RUN: begin
                    if (PCsrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (MULTI_EN && MultiE) begin
                        StallF    = 1'b1;
                        StallD    = 1'b1;
                        StallE    = 1'b1;
                        FlushM    = 1'b1;
                        stateNext = MULTI;
                        cntNext   = CNT_START;
                    end else if (loadUse) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end else begin
                        stateNext = RUN;
                    end
                end
                MULTI: begin
                    // Final cycle drops the stalls so E/M captures the result.
                    if (cntR != {CNT_W{1'b0}}) begin
                        StallF  = 1'b1;
                        StallD  = 1'b1;
                        StallE  = 1'b1;
                        FlushM  = 1'b1;
                        cntNext = cntR - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        stateNext = RUN;
                    end
                end
                default: begin
                    stateNext = RUN;
                    cntNext   = '0;
                end
            endcase
        end
    end

    // State, occupancy counter and saturating stall statistic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateR       <= RUN;
            cntR         <= '0;
            stall_cycles <= 32'd0;
        end else begin
            stateR <= stateNext;
            cntR   <= cntNext;
            if (StallF && (stall_cycles != STALL_SAT)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end else begin
                stall_cycles <= stall_cycles;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: random and directed stimulus against a
// behavioural model, two instances (N=4 default saturation, N=32 short saturation).
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE;
        logic       RegWriteE, MemtoRegE;
        logic [4:0] rdM;
        logic       RegWriteM;
        logic [4:0] rdW;
        logic       RegWriteW, PCsrcE, MultiE;
    } stim_t;

    typedef struct packed {
        logic [1:0]  fa, fb;
        logic        sf, sd, se, fd, fe, fm, busy;
        logic [31:0] sc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [4:0] rs1D = 5'd0, rs2D = 5'd0, rs1E = 5'd0, rs2E = 5'd0, rdE = 5'd0;
    logic       RegWriteE = 1'b0, MemtoRegE = 1'b0;
    logic [4:0] rdM = 5'd0, rdW = 5'd0;
    logic       RegWriteM = 1'b0, RegWriteW = 1'b0, PCsrcE = 1'b0, MultiE = 1'b0;

    logic [1:0]  fa4, fb4, fa32, fb32;
    logic        sf4, sd4, se4, fd4, fe4, fm4, bz4;
    logic        sf32, sd32, se32, fd32, fe32, fm32, bz32;
    logic [31:0] sc4, sc32;

    hazard_ctrl #(.MULDIV_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .rdM(rdM),
        .RegWriteM(RegWriteM), .rdW(rdW), .RegWriteW(RegWriteW), .PCsrcE(PCsrcE),
        .MultiE(MultiE), .ForwardAE(fa4), .ForwardBE(fb4), .StallF(sf4), .StallD(sd4),
        .StallE(se4), .FlushD(fd4), .FlushE(fe4), .FlushM(fm4), .busy(bz4),
        .stall_cycles(sc4)
    );

    hazard_ctrl #(.MULDIV_CYCLES(32), .STALL_SAT(32'd40)) dut32 (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .rdM(rdM),
        .RegWriteM(RegWriteM), .rdW(rdW), .RegWriteW(RegWriteW), .PCsrcE(PCsrcE),
        .MultiE(MultiE), .ForwardAE(fa32), .ForwardBE(fb32), .StallF(sf32), .StallD(sd32),
        .StallE(se32), .FlushD(fd32), .FlushE(fe32), .FlushM(fm32), .busy(bz32),
        .stall_cycles(sc32)
    );

    exp_t act4, act32;
    assign act4  = {fa4, fb4, sf4, sd4, se4, fd4, fe4, fm4, bz4, sc4};
    assign act32 = {fa32, fb32, sf32, sd32, se32, fd32, fe32, fm32, bz32, sc32};

    exp_t q4[$];
    exp_t q32[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: remaining E occupancy and stall count, per instance.
    int unsigned rem[2];
    logic [31:0] scm[2];

    function automatic logic [1:0] fwdRef(input logic [4:0] rs, input stim_t s);
        if (s.RegWriteM && s.rdM != 5'd0 && s.rdM == rs) return 2'b10;
        if (s.RegWriteW && s.rdW != 5'd0 && s.rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model(input int k, input stim_t s, output exp_t e);
        int unsigned n;
        logic [31:0] sat;
        logic        lu;
        n   = (k == 1) ? 32 : 4;
        sat = (k == 1) ? 32'd40 : 32'hFFFF_FFFF;
        e   = '0;
        if (s.rst) begin
            rem[k] = 0;
            scm[k] = 32'd0;
        end else begin
            lu     = s.MemtoRegE && s.RegWriteE && s.rdE != 5'd0 &&
                     (s.rdE == s.rs1D || s.rdE == s.rs2D);
            e.fa   = fwdRef(s.rs1E, s);
            e.fb   = fwdRef(s.rs2E, s);
            e.sc   = scm[k];
            e.busy = (rem[k] > 0);
            if (rem[k] > 0) begin
                if (rem[k] > 1) {e.sf, e.sd, e.se, e.fm} = 4'b1111;
                rem[k] = rem[k] - 1;
            end else if (s.PCsrcE) begin
                e.fd = 1'b1;
                e.fe = 1'b1;
            end else if (s.MultiE && n > 1) begin
                {e.sf, e.sd, e.se, e.fm} = 4'b1111;
                rem[k] = n - 1;
            end else if (lu) begin
                e.sf = 1'b1;
                e.sd = 1'b1;
                e.fe = 1'b1;
            end
            if (e.sf && scm[k] != sat) scm[k] = scm[k] + 32'd1;
        end
    endtask

    task automatic cyc(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst = s.rst; rs1D = s.rs1D; rs2D = s.rs2D; rs1E = s.rs1E; rs2E = s.rs2E;
        rdE = s.rdE; RegWriteE = s.RegWriteE; MemtoRegE = s.MemtoRegE;
        rdM = s.rdM; RegWriteM = s.RegWriteM; rdW = s.rdW; RegWriteW = s.RegWriteW;
        PCsrcE = s.PCsrcE; MultiE = s.MultiE;
        model(0, s, e); q4.push_back(e);
        model(1, s, e); q32.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic cmpAll(input string tag, input exp_t a, input exp_t e);
        chk({tag, ".ForwardAE"},    32'(a.fa),   32'(e.fa));
        chk({tag, ".ForwardBE"},    32'(a.fb),   32'(e.fb));
        chk({tag, ".StallF"},       32'(a.sf),   32'(e.sf));
        chk({tag, ".StallD"},       32'(a.sd),   32'(e.sd));
        chk({tag, ".StallE"},       32'(a.se),   32'(e.se));
        chk({tag, ".FlushD"},       32'(a.fd),   32'(e.fd));
        chk({tag, ".FlushE"},       32'(a.fe),   32'(e.fe));
        chk({tag, ".FlushM"},       32'(a.fm),   32'(e.fm));
        chk({tag, ".busy"},         32'(a.busy), 32'(e.busy));
        chk({tag, ".stall_cycles"}, a.sc,        e.sc);
    endtask

    // Monitor: outputs are valid every cycle, so pop one expectation per falling edge.
    always @(negedge clk) begin
        if (q4.size() > 0)  cmpAll("d4",  act4,  q4.pop_front());
        if (q32.size() > 0) cmpAll("d32", act32, q32.pop_front());
    end

    initial begin
        stim_t s;
        rem[0] = 0; rem[1] = 0; scm[0] = 32'd0; scm[1] = 32'd0;

        s = '0; s.rst = 1'b1; cyc(s); cyc(s);
        s = '0; cyc(s);
        // Forwarding priority: M, then W, then register file.
        s.rs1E = 5'd5; s.rdM = 5'd5; s.RegWriteM = 1'b1; s.rdW = 5'd5; s.RegWriteW = 1'b1; cyc(s);
        s.rdM = 5'd0; cyc(s);
        s.rdW = 5'd0; cyc(s);
        // Load-use bubble, then W forwarding of the loaded value.
        s = '0; s.MemtoRegE = 1'b1; s.RegWriteE = 1'b1; s.rdE = 5'd7; s.rs2D = 5'd7; cyc(s);
        s = '0; s.rdW = 5'd7; s.RegWriteW = 1'b1; s.rs2E = 5'd7; cyc(s);
        // Branch beats load-use.
        s = '0; s.MemtoRegE = 1'b1; s.RegWriteE = 1'b1; s.rdE = 5'd7; s.rs1D = 5'd7;
        s.PCsrcE = 1'b1; cyc(s);
        // Multi-cycle op held for N=4 cycles.
        s = '0; s.MultiE = 1'b1; repeat (4) cyc(s);
        s = '0; repeat (3) cyc(s);
        // Reset in the 10th MULTI cycle of the N=32 instance.
        s = '0; s.rst = 1'b1; cyc(s);
        s = '0; s.MultiE = 1'b1; cyc(s);
        s = '0; repeat (9) cyc(s);
        s.rst = 1'b1; cyc(s);
        s = '0; repeat (3) cyc(s);
        // Two full N=32 ops drive the short counter into saturation.
        repeat (2) begin
            s = '0; s.MultiE = 1'b1; cyc(s);
            s = '0; repeat (32) cyc(s);
        end
        repeat (3) cyc(s);

        for (int i = 0; i < 1500; i++) begin
            s           = '0;
            s.rst       = ($urandom_range(0, 149) == 0);
            s.rs1D      = 5'($urandom_range(0, 3));
            s.rs2D      = 5'($urandom_range(0, 3));
            s.rs1E      = 5'($urandom_range(0, 3));
            s.rs2E      = 5'($urandom_range(0, 3));
            s.rdE       = 5'($urandom_range(0, 3));
            s.rdM       = 5'($urandom_range(0, 3));
            s.rdW       = 5'($urandom_range(0, 3));
            s.RegWriteE = 1'($urandom_range(0, 1));
            s.RegWriteM = 1'($urandom_range(0, 1));
            s.RegWriteW = 1'($urandom_range(0, 1));
            s.MemtoRegE = ($urandom_range(0, 2) == 0);
            s.PCsrcE    = ($urandom_range(0, 9) == 0);
            s.MultiE    = ($urandom_range(0, 9) == 0);
            cyc(s);
        end

        repeat (2) @(negedge clk);
        #1;
        chk("q4.drained",  32'(q4.size()),  32'd0);
        chk("q32.drained", 32'(q32.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage core. It drives the execute stage's operand-forwarding selects and its E/M-register flush, and issues the stall and flush controls for the F, D and E stages. It sequences three cases: load-use bubbles, taken-branch/jump squashes, and multi-cycle execute operations such as the iterative mul/div unit, which holds E for `MULDIV_CYCLES` cycles. It sits beside the pipeline and is purely a control block: it carries no datapath.

## Interface
- `MULDIV_CYCLES`, default 32: execute occupancy of a multi-cycle op, in cycles; legal range 1..65535.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `rs1D`, `rs2D` in 5 each: source registers of the instruction in D.
- `rs1E`, `rs2E` in 5 each: source registers of the instruction in E.
- `rdE` in 5, `RegWriteE` in 1, `MemtoRegE` in 1: destination and controls of the instruction in E.
- `rdM` in 5, `RegWriteM` in 1: destination and write-enable of the instruction in M.
- `rdW` in 5, `RegWriteW` in 1: destination and write-enable of the instruction in W.
- `PCsrcE` in 1: taken branch/jump resolved in E.
- `MultiE` in 1: the instruction in E is a multi-cycle op.
- `ForwardAE`, `ForwardBE` out 2 each: operand source select. 00 = register file, 01 = resultW, 10 = ALUoutM; 11 is never driven.
- `StallF`, `StallD`, `StallE` out 1 each: hold the PC, the F/D register and the D/E register.
- `FlushD`, `FlushE` out 1 each: clear the F/D register and the D/E register.
- `FlushM` out 1: clear the E/M register; wired to the execute stage's `flush`.
- `busy` out 1: high while the FSM is in MULTI.
- `stall_cycles` out 32: saturating count of cycles with `StallF` high.

## Operation
- **Forwarding** (combinational, per operand; shown for `rs1E`, identical for `rs2E`):
  - 10 if `RegWriteM`, `rdM!=0` and `rdM==rs1E`.
  - Otherwise 01 if `RegWriteW`, `rdW!=0` and `rdW==rs1E`.
  - Otherwise 00.
  - M has priority over W. Forwarding is evaluated in every state.
- **FSM states:** RUN and MULTI, plus a down-counter `cnt` of 16 bits.
- **RUN**, evaluated in this priority order:
  1. `PCsrcE`: assert `FlushD` and `FlushE`. No stall.
  2. `MultiE` with `MULDIV_CYCLES>1`: assert `StallF`, `StallD`, `StallE` and `FlushM`. Next state is MULTI with `cnt=MULDIV_CYCLES-2`.
  3. Load-use, defined as `MemtoRegE & RegWriteE & rdE!=0 & (rdE==rs1D | rdE==rs2D)`: assert `StallF`, `StallD` and `FlushE` for exactly one cycle.
  4. Otherwise all stall and flush outputs are 0.
- `MultiE` with `MULDIV_CYCLES==1` is a no-op; the FSM stays in RUN.
- **MULTI:**
  - `cnt!=0`: assert `StallF`, `StallD`, `StallE` and `FlushM`; `cnt` decrements.
  - `cnt==0`: deassert all stalls and `FlushM` so the result latches into E/M; next state is RUN.
  - `MultiE`, `PCsrcE` and load-use are ignored while in MULTI.
- **stall_cycles:** increments on every edge where `StallF==1` and saturates at 0xFFFFFFFF.

## Timing
- **Reset values:** state RUN, `cnt=0`, `stall_cycles=0`. While `rst` is high, every stall and flush output is 0, both forward selects are 00, and `busy=0`.
- **Reset mid-MULTI:** immediate return to RUN with no residual stall.
- **Forwarding, load-use, branch flush:** zero latency, all combinational from the current inputs.
- **Multi-cycle op:** if `MultiE` is first seen in RUN at cycle t:
  - Stalls and `FlushM` are high in cycles t through t+N-2, where N = `MULDIV_CYCLES`.
  - They are low in cycle t+N-1; E/M captures the result at the end of t+N-1.
  - `busy` is high in cycles t+1 through t+N-1.
  - E occupancy is exactly N cycles.
- **Back-to-back multi ops:** the following op enters E at t+N and is seen in RUN, so it restarts immediately.
- **`PCsrcE` together with load-use:** the branch wins. No stall; `FlushE` removes the dependent instruction.
- **Load followed by a dependent instruction:** exactly one bubble, then W→E forwarding (select 01).

## Structure
- Package `hazard_pkg` holds:
  - the state enum (RUN, MULTI);
  - forward-select constants `FWD_RF=2'b00`, `FWD_W=2'b01`, `FWD_M=2'b10`;
  - the counter width constant (16).
- Sub-module `fwd_sel` is the per-operand comparator; `hazard_ctrl` instantiates it twice, once for A and once for B. The FSM and `stall_cycles` live in `hazard_ctrl`.

## Test plan
- **Forwarding:** `rs1E=5`, `rdM=5`, `RegWriteM=1`, `rdW=5`, `RegWriteW=1` → `ForwardAE=10`. With `rdM=0` → `ForwardAE=01`. With `rdW=0` as well → `ForwardAE=00`.
- **Load-use:** `MemtoRegE=1`, `RegWriteE=1`, `rdE=7`, `rs2D=7` → `StallF`, `StallD`, `FlushE` = 1 for one cycle, then 0; `stall_cycles` becomes 1.
- **Branch:** `PCsrcE=1` in the same cycle as a load-use condition → `FlushD=FlushE=1`, `StallF=0`, `stall_cycles` unchanged.
- **Multi-cycle op:** `MULDIV_CYCLES=4`, `MultiE` held high → stalls and `FlushM` high for 3 cycles and low on the 4th; `busy` high for 3 cycles; `stall_cycles=3`.
- **Reset mid-op:** `MULDIV_CYCLES=32`, `rst` pulsed in the 10th MULTI cycle → all outputs 0 asynchronously; RUN after release; `stall_cycles=0`.
- **Saturation:** preload by running past 2^32 stall cycles, or in a bench-overridden short variant → the counter holds at 0xFFFFFFFF.
